// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor sequencer: one full-subtractor cell, LSB first, registered borrow.
// Optional borrow-in port enabled by defining SERIAL_SUB_BIN_EN.
module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
`ifdef SERIAL_SUB_BIN_EN
    input  logic             i_bin,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_x, r_y, r_res, r_diff;
    logic [WIDTH-1:0] w_x_nxt, w_y_nxt, w_res_nxt, w_diff_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_br, w_br_nxt;
    logic             r_bout, w_bout_nxt;
    logic             r_busy, r_done;
    logic             w_d, w_b, w_seed;
    logic [WIDTH-1:0] w_res_shift;

`ifdef SERIAL_SUB_BIN_EN
    assign w_seed = i_bin;
`else
    assign w_seed = 1'b0;
`endif

    // Shared full-subtractor cell on the current LSB pair
    assign w_d         = r_x[0] ^ r_y[0] ^ r_br;
    assign w_b         = (~r_x[0] & r_y[0]) | (~(r_x[0] ^ r_y[0]) & r_br);
    assign w_res_shift = {w_d, r_res[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_res_nxt   = r_res;
        w_cnt_nxt   = r_cnt;
        w_br_nxt    = r_br;
        w_diff_nxt  = r_diff;
        w_bout_nxt  = r_bout;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_x_nxt     = i_x;
                    w_y_nxt     = i_y;
                    w_br_nxt    = w_seed;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                w_x_nxt   = r_x >> 1;
                w_y_nxt   = r_y >> 1;
                w_res_nxt = w_res_shift;
                w_br_nxt  = w_b;
                w_cnt_nxt = r_cnt + CW'(1);
                // Last bit: publish result and final borrow
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_diff_nxt  = w_res_shift;
                    w_bout_nxt  = w_b;
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_res   <= w_res_nxt;
            r_cnt   <= w_cnt_nxt;
            r_br    <= w_br_nxt;
            r_diff  <= w_diff_nxt;
            r_bout  <= w_bout_nxt;
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_diff = r_diff;
    assign o_bout = r_bout;

endmodule
